rgb_fade_pwm: RTL and testbench
===============================

RGB_FADE_PWM -- requirements
Module: rgb_fade_pwm

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
REQ-002 FADE_STEP_CYCLES, 12000, clk cycles per fade step (1 ms at 12 MHz); legal range 1..2^20.
REQ-003 Ports SHALL be one per line: name, direction, width, meaning.
REQ-004 clk  input  1  single 12 MHz clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 color_in  input  3  target colour {R,G,B}; 1 = full on, 0 = off.
REQ-007 color_valid  input  1  color_in is valid this cycle.
REQ-008 color_ready  output  1  block accepts a new target this cycle.
REQ-009 RGB_R  output  1  red PWM drive, active-high.
REQ-010 RGB_G  output  1  green PWM drive, active-high.
REQ-011 RGB_B  output  1  blue PWM drive, active-high.

Function
REQ-012 Free-running 8-bit PWM counter SHALL count 0..255 and wrap to 0; PWM period is 256 cycles.
REQ-013 Each channel SHALL hold an 8-bit fade level, an 8-bit target (0x00 or 0xFF) and an 8-bit applied duty.
REQ-014 Applied duty SHALL load from the fade level (gamma-mapped per REQ-027) only in the cycle the PWM counter equals 255, so duty never changes mid-period.
REQ-015 Channel output SHALL be 1 when applied duty == 255 or counter < applied duty, else 0; duty 0 gives constant 0 and duty 255 gives constant 1.
REQ-016 Outputs SHALL be registered: one cycle of latency from counter/duty to pin.
REQ-017 FSM states SHALL be IDLE and FADING; color_ready = 1 only in IDLE, and only when not in reset.
REQ-018 Handshake: a transfer SHALL occur when color_valid and color_ready are both 1; targets latch from color_in and the FSM enters FADING in the next cycle.
REQ-019 In FADING, color_valid SHALL be ignored and color_in SHALL NOT be sampled.
REQ-020 A step counter SHALL count 0..FADE_STEP_CYCLES-1 while in FADING, starting from 0 on entry; at terminal count, each channel level SHALL move by exactly 1 toward its target, saturating at the target.
REQ-021 FADING SHALL return to IDLE in the cycle after all three levels equal their targets; a target equal to the current levels SHALL give exactly one FADING cycle.
REQ-022 A full fade from 0x00 to 0xFF SHALL take 255*FADE_STEP_CYCLES cycles of FADING plus one cycle.
REQ-023 Channels SHALL fade independently and concurrently: rising, falling, and unchanged channels may coexist in a single fade.

Reset
REQ-024 While rst_n = 0 at posedge clk: PWM counter, step counter, all levels, targets and applied duties SHALL clear to 0, FSM SHALL go to IDLE, and RGB_R/G/B and color_ready SHALL be 0.
REQ-025 Reset asserted mid-fade SHALL abort the fade with no residual state; color_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-026 Macro RGB_FADE_GAMMA_EN SHALL select the duty mapping at compile time.
REQ-027 With RGB_FADE_GAMMA_EN defined, applied duty SHALL be (level*level + 255) >> 8, using 16-bit arithmetic (0->0, 1->1, 16->1, 128->64, 255->255); without it, applied duty SHALL equal level.

Verification
REQ-028 Hold rst_n=0 for 4 cycles, then release -> RGB_R/G/B = 0 throughout; color_ready = 1 in the first cycle after release.
REQ-029 With FADE_STEP_CYCLES=1 and no gamma, send color_in=3'b100 -> color_ready = 0 for 256 cycles; red level reaches 255; G and B stay 0; RGB_R is then constantly 1.
REQ-030 Force red level to 64 (no gamma) -> RGB_R is high for exactly 64 of every 256 cycles, and the duty changes only at the counter wrap.
REQ-031 Assert color_valid with color_in=3'b011 during a fade -> no transfer occurs; targets are unchanged; the fade completes to the original target.
REQ-032 Assert rst_n=0 mid-fade, with red level at 100 -> all levels are 0, outputs are 0, and the FSM is in IDLE after release.
REQ-033 Build with RGB_FADE_GAMMA_EN and set level 128 -> RGB_R is high for 64 of every 256 cycles; at level 255, RGB_R is constantly 1.

Source files
------------

// File: rtl/rgb_fade_pwm.sv
// rtl/rgb_fade_pwm.sv - RGB LED fader with per-channel 8-bit PWM; gamma duty mapping when RGB_FADE_GAMMA_EN is defined
module rgb_fade_pwm #(
  parameter int FADE_STEP_CYCLES = 12000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] color_in,
  input  logic       color_valid,
  output logic       color_ready,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B
);

  localparam logic IDLE   = 1'b0;
  localparam logic FADING = 1'b1;

  // Step counter is wide enough for the largest legal step length (2^20 cycles).
  localparam logic [19:0] STEP_LAST = 20'(FADE_STEP_CYCLES - 1);

  // Channel index 2 = red, 1 = green, 0 = blue, matching color_in = {R,G,B}.
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [19:0]      step_q, step_d;
  logic             state_q, state_d;
  logic [2:0][7:0]  level_q, level_d;
  logic [2:0][7:0]  target_q, target_d;
  logic [2:0][7:0]  duty_q, duty_d;
  logic [2:0]       rgb_q, rgb_d;
  logic             xfer;

  // Move one LSB toward the target, holding once it is reached.
  function automatic logic [7:0] step_toward(input logic [7:0] lvl, input logic [7:0] tgt);
    if (lvl < tgt) begin
      return lvl + 8'd1;
    end else if (lvl > tgt) begin
      return lvl - 8'd1;
    end else begin
      return lvl;
    end
  endfunction

  // Level-to-duty mapping: square-law curve when gamma is enabled, identity otherwise.
  function automatic logic [7:0] map_duty(input logic [7:0] lvl);
`ifdef RGB_FADE_GAMMA_EN
    logic [15:0] sq;
    sq = 16'(lvl) * 16'(lvl) + 16'd255;
    return sq[15:8];
`else
    return lvl;
`endif
  endfunction

  assign color_ready = rst_n & (state_q == IDLE);
  assign xfer        = color_valid & color_ready;

  // Next-state logic: handshake, fade stepping, duty reload at wrap, PWM compare.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    state_d   = state_q;
    step_d    = step_q;
    level_d   = level_q;
    target_d  = target_q;
    duty_d    = duty_q;
    rgb_d     = '0;

    if (state_q == IDLE) begin
      if (xfer) begin
        for (int i = 0; i < 3; i++) begin
          target_d[i] = {8{color_in[i]}};
        end
        state_d = FADING;
        step_d  = '0;
      end
    end else begin
      // Exit is decided on registered levels, so an already-matched target costs one cycle.
      if (level_q == target_q) begin
        state_d = IDLE;
      end else if (step_q == STEP_LAST) begin
        step_d = '0;
        for (int i = 0; i < 3; i++) begin
          level_d[i] = step_toward(level_q[i], target_q[i]);
        end
      end else begin
        step_d = step_q + 20'd1;
      end
    end

    // Duty only reloads on the last count so a period is never split between two duties.
    if (pwm_cnt_q == 8'hFF) begin
      for (int i = 0; i < 3; i++) begin
        duty_d[i] = map_duty(level_q[i]);
      end
    end

    for (int i = 0; i < 3; i++) begin
      rgb_d[i] = (duty_q[i] == 8'hFF) || (pwm_cnt_q < duty_q[i]);
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      step_q    <= '0;
      state_q   <= IDLE;
      level_q   <= '0;
      target_q  <= '0;
      duty_q    <= '0;
      rgb_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      step_q    <= step_d;
      state_q   <= state_d;
      level_q   <= level_d;
      target_q  <= target_d;
      duty_q    <= duty_d;
      rgb_q     <= rgb_d;
    end
  end

  assign RGB_R = rgb_q[2];
  assign RGB_G = rgb_q[1];
  assign RGB_B = rgb_q[0];

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// tb/tb_rgb_fade_pwm.sv - directed bench for rgb_fade_pwm (fast-step and slow-step instances)
module tb_rgb_fade_pwm;

  localparam int SLOW_N = 600;
`ifdef RGB_FADE_GAMMA_EN
  localparam int EXP_DUTY64 = 16;
`else
  localparam int EXP_DUTY64 = 64;
`endif

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [2:0] color_in, color2_in;
  logic       color_valid, color2_valid;
  logic       color_ready, color2_ready;
  logic       r_o, g_o, b_o, r2_o, g2_o, b2_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // Cycle index of the slow instance: after posedge k since release its PWM counter is k mod 256.
  always @(posedge clk) begin
    if (!rst2_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  rgb_fade_pwm #(.FADE_STEP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .color_in(color_in), .color_valid(color_valid),
    .color_ready(color_ready), .RGB_R(r_o), .RGB_G(g_o), .RGB_B(b_o)
  );

  rgb_fade_pwm #(.FADE_STEP_CYCLES(SLOW_N)) dut2 (
    .clk(clk), .rst_n(rst2_n), .color_in(color2_in), .color_valid(color2_valid),
    .color_ready(color2_ready), .RGB_R(r2_o), .RGB_G(g2_o), .RGB_B(b2_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Handshake on the next posedge, then count FADING cycles by sampling ready at negedges.
  task automatic fade(input logic [2:0] col, input int glitch, output int busy, output int gb_hi);
    color_in = col;
    color_valid = 1'b1;
    @(posedge clk);
    #1 color_valid = 1'b0;
    busy = 0;
    gb_hi = 0;
    @(negedge clk);
    while (!color_ready && busy < 400) begin
      if (glitch != 0 && busy == 10) begin
        color_in = 3'b011;
        color_valid = 1'b1;
      end
      if (busy == 30) color_valid = 1'b0;
      gb_hi += int'(g_o) + int'(b_o);
      busy++;
      @(negedge clk);
    end
    color_valid = 1'b0;
  endtask

  task automatic measure(input int n, output int hr, output int hg, output int hb);
    hr = 0; hg = 0; hb = 0;
    repeat (n) begin
      @(negedge clk);
      hr += int'(r_o); hg += int'(g_o); hb += int'(b_o);
    end
  endtask

  initial begin
    int busy, gb, hr, hg, hb, h2, start, hi2, bad2;

    rst_n = 1'b0; rst2_n = 1'b0;
    color_in = 3'b000; color_valid = 1'b0;
    color2_in = 3'b000; color2_valid = 1'b0;

    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_rgb", int'({r_o, g_o, b_o}), 0);
      check("reset_ready", int'(color_ready), 0);
    end
    rst_n = 1'b1; rst2_n = 1'b1;
    #1;
    check("release_ready", int'(color_ready), 1);
    check("release_ready2", int'(color2_ready), 1);
    check("release_rgb", int'({r_o, g_o, b_o}), 0);

    // Slow instance starts a red fade on the same edge as the fast one.
    color2_in = 3'b100;
    color2_valid = 1'b1;
    fork
      begin
        @(posedge clk);
        #1 color2_valid = 1'b0;
        h2 = cyc;
      end
      fade(3'b100, 0, busy, gb);
    join
    check("red_up_busy", busy, 256);
    check("red_up_gb_high", gb, 0);
    measure(260, hr, hg, hb);
    measure(256, hr, hg, hb);
    check("red_full_r", hr, 256);
    check("red_full_g", hg, 0);
    check("red_full_b", hb, 0);

    // Mixed fade (red down, green up, blue held) with an ignored request mid-fade.
    fade(3'b010, 1, busy, gb);
    check("mixed_busy", busy, 256);
    measure(260, hr, hg, hb);
    measure(256, hr, hg, hb);
    check("mixed_r", hr, 0);
    check("mixed_g", hg, 256);
    check("mixed_b", hb, 0);

    fade(3'b010, 0, busy, gb);
    check("same_target_busy", busy, 1);

    // Reset while red has reached 100.
    color_in = 3'b100;
    color_valid = 1'b1;
    @(posedge clk);
    #1 color_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("midreset_rgb", int'({r_o, g_o, b_o}), 0);
      check("midreset_ready", int'(color_ready), 0);
    end
    rst_n = 1'b1;
    #1;
    check("midreset_release_ready", int'(color_ready), 1);
    measure(300, hr, hg, hb);
    check("post_reset_high", hr + hg + hb, 0);
    fade(3'b000, 0, busy, gb);
    check("post_reset_zero_busy", busy, 1);

    // Slow instance: red level is 64 over this window; check high count and phase.
    start = h2 + 64 * SLOW_N + 258;
    while (cyc < start) @(negedge clk);
    hi2 = 0;
    bad2 = 0;
    for (int i = 0; i < 256; i++) begin
      hi2 += int'(r2_o);
      if (r2_o !== (((cyc - 1) % 256) < EXP_DUTY64)) bad2++;
      @(negedge clk);
    end
    check("level64_high", hi2, EXP_DUTY64);
    check("level64_phase_err", bad2, 0);
    check("level64_busy", int'(color2_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
